task3_txn_ctrl: RTL and testbench

Transaction controller that produces the protocol signal set checked by the task3 formal top: ready, start, enable, end, stop, error, retry, status-valid, interrupt and a req/ack handshake. It accepts transaction requests from a host, runs a length-counted beat phase against a downstream `beat_ok` qualifier, and applies a stall timeout with bounded retries. It sits directly upstream of the task3 property top and drives its signals legally by construction.

---
 rtl/task3_pkg.sv | 25 ++
 rtl/task3_stall_timer.sv | 68 ++++++
 rtl/task3_txn_ctrl.sv | 166 ++++++++++++++++
 tb/tb_task3_txn_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/task3_pkg.sv
// Shared definitions for the task3 transaction controller.
//   txn_state_e : controller state encoding (also exported for debug)
//   DEF_*       : default parameter values
//   len_width() : width of the transaction length field for a given MAX_LEN
package task3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_STAT  = 3'd4,
        ST_ERR   = 3'd5
    } txn_state_e;

    localparam int DEF_MAX_LEN   = 8;
    localparam int DEF_TIMEOUT   = 4;
    localparam int DEF_RETRY_MAX = 2;

    // Enough bits to hold 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/task3_stall_timer.sv
// Stall timeout and retry bookkeeping for the RUN phase.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : transaction start, clears both counters
//   beat_i    : a beat was transferred, clears the stall count
//   stall_i   : a RUN cycle with no beat and no abort
//   retry_o   : this stalled cycle is the TIMEOUT-th and a retry is still allowed
//   expire_o  : this stalled cycle is the TIMEOUT-th and retries are exhausted
module task3_stall_timer
    import task3_pkg::*;
#(
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int RETRY_MAX = DEF_RETRY_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic beat_i,
    input  logic stall_i,
    output logic retry_o,
    output logic expire_o
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    logic [SW-1:0] stall_q, stall_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          timeout;
    logic          can_retry;

    // The count holds completed stalls, so the TIMEOUT-th stall is seen
    // while the count still reads TIMEOUT-1.
    assign timeout   = stall_i && (stall_q == SW'(TIMEOUT - 1));
    assign can_retry = (retry_q < RW'(RETRY_MAX));
    assign retry_o   = timeout && can_retry;
    assign expire_o  = timeout && !can_retry;

    always_comb begin
        stall_d = stall_q;
        retry_d = retry_q;
        if (clear_i) begin
            stall_d = '0;
            retry_d = '0;
        end else if (beat_i) begin
            stall_d = '0;
        end else if (stall_i) begin
            if (timeout) begin
                stall_d = '0;
            end else begin
                stall_d = stall_q + 1'b1;
            end
            if (retry_o) begin
                retry_d = retry_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            retry_q <= '0;
        end else begin
            stall_q <= stall_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: rtl/task3_txn_ctrl.sv
// Transaction controller: accepts a host request with a beat count, runs a
// length-counted beat phase qualified by beat_ok, retries on stall timeout
// and reports completion, abort, error and a sticky interrupt.
//   clk, rst      : clock, asynchronous active-high reset
//   req, len      : host request and beat count, sampled in IDLE
//   beat_ok       : downstream accepts a beat this cycle
//   abort         : host abort, honoured in RUN only
//   irq_en/irq_clr: interrupt set enable / sticky clear
//   ack, stop, rt : registered one-cycle pulses
//   rdy, start, endd, status_valid, er : state-decoded strobes
//   enable        : beat transferred this cycle (RUN & beat_ok)
//   interrupt     : sticky interrupt
//   dbg_state_o   : current FSM state
//
// Handshake: req is a level; the controller answers with a one-cycle ack the
// cycle after sampling it in IDLE. A req still high when IDLE is re-entered
// is taken as a new transaction.
module task3_txn_ctrl
    import task3_pkg::*;
#(
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int RETRY_MAX = DEF_RETRY_MAX,
    localparam int LW       = len_width(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [LW-1:0] len,
    input  logic          beat_ok,
    input  logic          abort,
    input  logic          irq_en,
    input  logic          irq_clr,
    output logic          ack,
    output logic          rdy,
    output logic          start,
    output logic          enable,
    output logic          endd,
    output logic          status_valid,
    output logic          stop,
    output logic          er,
    output logic          rt,
    output logic          interrupt,
    output txn_state_e    dbg_state_o
);

    txn_state_e    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          ack_q, ack_d;
    logic          stop_q, stop_d;
    logic          rt_q, rt_d;
    logic          irq_q, irq_d;

    logic          in_run;
    logic          beat;
    logic          retry;
    logic          expire;
    logic          len_legal;
    logic          irq_set;

    assign in_run    = (state_q == ST_RUN);
    assign beat      = in_run && beat_ok;
    assign len_legal = (len != '0) && (len <= LW'(MAX_LEN));

    // Abort pre-empts the timeout, so an aborted cycle never counts as a stall.
    task3_stall_timer #(
        .TIMEOUT   (TIMEOUT),
        .RETRY_MAX (RETRY_MAX)
    ) u_stall_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == ST_START),
        .beat_i   (beat),
        .stall_i  (in_run && !beat_ok && !abort),
        .retry_o  (retry),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        ack_d   = 1'b0;
        stop_d  = 1'b0;
        rt_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    len_d   = len;
                    ack_d   = 1'b1;
                    state_d = len_legal ? ST_START : ST_ERR;
                end
            end
            ST_START: begin
                rem_d   = len_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (beat_ok) begin
                    rem_d = rem_q - 1'b1;
                end
                if (abort) begin
                    stop_d  = 1'b1;
                    state_d = ST_ERR;
                end else if (beat_ok && (rem_q == LW'(1))) begin
                    state_d = ST_DONE;
                end else if (retry) begin
                    rt_d = 1'b1;
                end else if (expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_STAT;
            ST_STAT: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Set on the transition into DONE or ERR; set beats a simultaneous clear.
    assign irq_set = irq_en && (state_d != state_q) &&
                     ((state_d == ST_DONE) || (state_d == ST_ERR));

    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            ack_q   <= 1'b0;
            stop_q  <= 1'b0;
            rt_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            ack_q   <= ack_d;
            stop_q  <= stop_d;
            rt_q    <= rt_d;
            irq_q   <= irq_d;
        end
    end

    assign rdy          = (state_q == ST_IDLE);
    assign start        = (state_q == ST_START);
    assign endd         = (state_q == ST_DONE);
    assign status_valid = (state_q == ST_STAT);
    assign er           = (state_q == ST_ERR);
    assign enable       = beat;
    assign ack          = ack_q;
    assign stop         = stop_q;
    assign rt           = rt_q;
    assign interrupt    = irq_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_task3_txn_ctrl.sv
module tb_task3_txn_ctrl;
  import task3_pkg::*;

  // Output vector bit order: {ack,rdy,start,enable,endd,status_valid,stop,er,rt,interrupt}
  localparam logic [9:0] NONE  = 10'h000;
  localparam logic [9:0] ACK   = 10'h200;
  localparam logic [9:0] RDY   = 10'h100;
  localparam logic [9:0] START = 10'h080;
  localparam logic [9:0] EN    = 10'h040;
  localparam logic [9:0] ENDD  = 10'h020;
  localparam logic [9:0] SV    = 10'h010;
  localparam logic [9:0] STOP  = 10'h008;
  localparam logic [9:0] ER    = 10'h004;
  localparam logic [9:0] RT    = 10'h002;
  localparam logic [9:0] IRQ   = 10'h001;

  typedef struct {
    string      name;
    logic       req;
    logic [3:0] len;
    logic       bo;
    logic       ab;
    logic       ie;
    logic       ic;
    logic [9:0] exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req = 1'b0;
  logic [3:0] len = '0;
  logic       beat_ok = 1'b0;
  logic       abort = 1'b0;
  logic       irq_en = 1'b0;
  logic       irq_clr = 1'b0;
  logic       ack, rdy, start, enable, endd, status_valid, stop, er, rt, interrupt;
  txn_state_e dbg_state;

  task3_txn_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .len          (len),
    .beat_ok      (beat_ok),
    .abort        (abort),
    .irq_en       (irq_en),
    .irq_clr      (irq_clr),
    .ack          (ack),
    .rdy          (rdy),
    .start        (start),
    .enable       (enable),
    .endd         (endd),
    .status_valid (status_valid),
    .stop         (stop),
    .er           (er),
    .rt           (rt),
    .interrupt    (interrupt),
    .dbg_state_o  (dbg_state)
  );

  int   total = 0;
  int   bad = 0;
  vec_t vq[$];

  function automatic logic [9:0] outs();
    return {ack, rdy, start, enable, endd, status_valid, stop, er, rt, interrupt};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b (ack,rdy,start,en,endd,sv,stop,er,rt,irq)", name, got, exp);
    end
  endtask

  task automatic add(input string n, input logic r, input logic [3:0] l, input logic b,
                     input logic a, input logic ie, input logic ic, input logic [9:0] e);
    vec_t v;
    v.name = n; v.req = r; v.len = l; v.bo = b; v.ab = a; v.ie = ie; v.ic = ic; v.exp = e;
    vq.push_back(v);
  endtask

  // One vector per cycle: drive just after the rising edge, compare mid-cycle.
  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      req = vq[i].req; len = vq[i].len; beat_ok = vq[i].bo;
      abort = vq[i].ab; irq_en = vq[i].ie; irq_clr = vq[i].ic;
      #2;
      check(vq[i].name, vq[i].exp);
    end
    vq.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", RDY);
    rst = 1'b0;

    // nominal len=3 with continuous beats
    add("nom_c0", 1, 4'd3, 1, 0, 0, 0, RDY);
    add("nom_c1", 0, 4'd0, 1, 0, 0, 0, ACK | START);
    add("nom_c2", 0, 4'd0, 1, 0, 0, 0, EN);
    add("nom_c3", 0, 4'd0, 1, 0, 0, 0, EN);
    add("nom_c4", 0, 4'd0, 1, 0, 0, 0, EN);
    add("nom_c5", 0, 4'd0, 0, 0, 0, 0, ENDD);
    add("nom_c6", 0, 4'd0, 0, 0, 0, 0, SV);
    add("nom_c7", 0, 4'd0, 0, 0, 0, 0, RDY);
    // illegal lengths 0 and 9
    add("len0_c0", 1, 4'd0, 0, 0, 0, 0, RDY);
    add("len0_c1", 0, 4'd0, 0, 0, 0, 0, ACK | ER);
    add("len0_c2", 0, 4'd0, 0, 0, 0, 0, RDY);
    add("len9_c0", 1, 4'd9, 0, 0, 0, 0, RDY);
    add("len9_c1", 0, 4'd0, 0, 0, 0, 0, ACK | ER);
    add("len9_c2", 0, 4'd0, 0, 0, 0, 0, RDY);
    // max legal length 8 accepted
    add("len8_c0", 1, 4'd8, 0, 0, 0, 0, RDY);
    add("len8_c1", 0, 4'd0, 0, 0, 0, 1, ACK | START);
    // abort it right away (no beat)
    add("len8_c2", 0, 4'd0, 0, 1, 0, 0, NONE);
    add("len8_c3", 0, 4'd0, 0, 0, 0, 0, STOP | ER);
    add("len8_c4", 0, 4'd0, 0, 0, 0, 0, RDY);
    run_vecs();

    // timeout: two retries then error, irq_en held high
    add("to_c0", 1, 4'd2, 0, 0, 1, 0, RDY);
    add("to_c1", 0, 4'd0, 0, 0, 1, 0, ACK | START);
    for (int c = 2; c <= 13; c++)
      add($sformatf("to_c%0d", c), 0, 4'd0, 0, 0, 1, 0, (c == 6 || c == 10) ? RT : NONE);
    add("to_c14", 0, 4'd0, 0, 0, 1, 0, ER | IRQ);
    add("to_c15", 0, 4'd0, 0, 0, 1, 1, RDY | IRQ);
    add("to_c16", 0, 4'd0, 0, 0, 1, 0, RDY);
    // one retry then completion
    add("rty_c0", 1, 4'd2, 0, 0, 0, 0, RDY);
    add("rty_c1", 0, 4'd0, 0, 0, 0, 0, ACK | START);
    add("rty_c2", 0, 4'd0, 0, 0, 0, 0, NONE);
    add("rty_c3", 0, 4'd0, 0, 0, 0, 0, NONE);
    add("rty_c4", 0, 4'd0, 0, 0, 0, 0, NONE);
    add("rty_c5", 0, 4'd0, 0, 0, 0, 0, NONE);
    add("rty_c6", 0, 4'd0, 1, 0, 0, 0, RT | EN);
    add("rty_c7", 0, 4'd0, 1, 0, 0, 0, EN);
    add("rty_c8", 0, 4'd0, 0, 0, 0, 0, ENDD);
    add("rty_c9", 0, 4'd0, 0, 0, 0, 0, SV);
    add("rty_c10", 0, 4'd0, 0, 0, 0, 0, RDY);
    // abort together with last beat
    add("ab_c0", 1, 4'd1, 0, 0, 0, 0, RDY);
    add("ab_c1", 0, 4'd0, 0, 0, 0, 0, ACK | START);
    add("ab_c2", 0, 4'd0, 1, 1, 0, 0, EN);
    add("ab_c3", 0, 4'd0, 0, 0, 0, 0, STOP | ER);
    add("ab_c4", 0, 4'd0, 0, 0, 0, 0, RDY);
    // interrupt set/clear collision on DONE entry
    add("col_c0", 1, 4'd3, 1, 0, 1, 0, RDY);
    add("col_c1", 0, 4'd0, 1, 0, 1, 0, ACK | START);
    add("col_c2", 0, 4'd0, 1, 0, 1, 0, EN);
    add("col_c3", 0, 4'd0, 1, 0, 1, 0, EN);
    add("col_c4", 0, 4'd0, 1, 0, 1, 1, EN);
    add("col_c5", 0, 4'd0, 0, 0, 1, 1, ENDD | IRQ);
    add("col_c6", 0, 4'd0, 0, 0, 1, 0, SV);
    add("col_c7", 0, 4'd0, 0, 0, 0, 0, RDY);
    // get interrupt set via illegal length, then begin a len=5 run
    add("pre_c0", 1, 4'd0, 0, 0, 1, 0, RDY);
    add("pre_c1", 0, 4'd0, 0, 0, 0, 0, ACK | ER | IRQ);
    add("pre_c2", 0, 4'd0, 0, 0, 0, 0, RDY | IRQ);
    add("mid_c0", 1, 4'd5, 1, 0, 0, 0, RDY | IRQ);
    add("mid_c1", 0, 4'd0, 1, 0, 0, 0, ACK | START | IRQ);
    add("mid_c2", 0, 4'd0, 1, 0, 0, 0, EN | IRQ);
    add("mid_c3", 0, 4'd0, 1, 0, 0, 0, EN | IRQ);
    run_vecs();

    // asynchronous reset in the middle of cycle 3
    rst = 1'b1;
    #1;
    check("async_reset", RDY);
    @(posedge clk);
    #1;
    check("reset_held", RDY);
    req = 1'b0; beat_ok = 1'b0;
    rst = 1'b0;

    // new transaction after reset completes normally
    add("post_c0", 1, 4'd1, 1, 0, 0, 0, RDY);
    add("post_c1", 0, 4'd0, 1, 0, 0, 0, ACK | START);
    add("post_c2", 0, 4'd0, 1, 0, 0, 0, EN);
    add("post_c3", 0, 4'd0, 0, 0, 0, 0, ENDD);
    add("post_c4", 0, 4'd0, 0, 0, 0, 0, SV);
    add("post_c5", 0, 4'd0, 0, 0, 0, 0, RDY);
    run_vecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
